// File: rtl/hazard_tracker.sv
// -----------------------------------------------------------------------------
// hazard_tracker
//
// Producer side of operand forwarding for a 5-stage RV32I pipeline.
// - Follows the destination register of every in-flight instruction through
//   EX, MEM and WB. Drives the per-stage rd values that the forwarding unit
//   compares against.
// - Detects load-use hazards that forwarding cannot cover. Holds IF/ID
//   (stall) and injects a NOP into EX (bubble).
//
// Parameters
//   LOAD_LATENCY  stall cycles per load-use hazard (1..7)
//   CNT_W         width of stall_count (present only with STALL_CNT_EN)
//
// Optional feature macro: STALL_CNT_EN
//   When defined, adds a saturating stall-cycle counter on port stall_count.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   id_valid      ID stage holds a real instruction
//   id_rs1/rs2    ID source registers
//   id_use_rs1/2  instruction actually reads rs1/rs2
//   id_rd         ID destination register
//   id_reg_write  instruction writes rd
//   id_is_load    instruction is a load
//   flush         taken branch/jump: kill ID->EX and cancel any stall
//   ex_rd         rd of EX entry (0 if invalid or not writing)
//   mem_rd        rd of MEM entry (same rule)
//   wb_rd         rd of WB entry (same rule)
//   stall         hold PC and IF/ID this cycle (combinational)
//   bubble        a NOP enters EX this cycle (stall | flush)
//   stall_count   total stall cycles, saturating (STALL_CNT_EN only)
// -----------------------------------------------------------------------------
module hazard_tracker #(
    parameter int LOAD_LATENCY = 1
`ifdef STALL_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] id_rd,
    input  logic       id_reg_write,
    input  logic       id_is_load,
    input  logic       flush,
    output logic [4:0] ex_rd,
    output logic [4:0] mem_rd,
    output logic [4:0] wb_rd,
    output logic       stall,
    output logic       bubble
`ifdef STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_count
`endif
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       is_load;
    } entry_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Extra HOLD cycles after the detection cycle.
    localparam logic [2:0] HOLD_CYCLES = 3'(LOAD_LATENCY - 1);
    localparam bit         MULTI_STALL = (LOAD_LATENCY > 1);

    entry_t     r_ex;
    entry_t     r_mem;
    entry_t     r_wb;
    state_e     r_state;
    logic [2:0] r_cnt;

    entry_t     w_id_entry;
    logic       w_haz;
    logic       w_stall;
    logic       w_capture;

    // is_load is only needed while the entry sits in EX.
    logic       w_unused;
    assign w_unused = r_mem.is_load ^ r_wb.is_load;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_id_entry           = '0;
        w_id_entry.valid     = 1'b1;
        w_id_entry.rd        = id_rd;
        // Writes to x0 are discarded at capture so x0 never hazards or forwards.
        w_id_entry.reg_write = id_reg_write && (id_rd != 5'd0);
        w_id_entry.is_load   = id_is_load;

        w_haz = r_ex.valid && r_ex.is_load && r_ex.reg_write && id_valid &&
                ((id_use_rs1 && (id_rs1 == r_ex.rd)) ||
                 (id_use_rs2 && (id_rs2 == r_ex.rd)));

        // flush beats everything; HOLD stalls regardless of id_valid.
        w_stall = 1'b0;
        if (!flush) begin
            if (r_state == ST_HOLD) w_stall = 1'b1;
            else                    w_stall = w_haz;
        end

        w_capture = id_valid && !w_stall && !flush;
    end

    assign stall  = w_stall;
    assign bubble = w_stall || flush;

    // Entries that were never captured are all-zero, so gating on valid and
    // reg_write yields 0 for bubbles, non-writers and x0.
    assign ex_rd  = (r_ex.valid  && r_ex.reg_write)  ? r_ex.rd  : 5'd0;
    assign mem_rd = (r_mem.valid && r_mem.reg_write) ? r_mem.rd : 5'd0;
    assign wb_rd  = (r_wb.valid  && r_wb.reg_write)  ? r_wb.rd  : 5'd0;

    // NOTE: sequential state uses non-blocking assignments so the stage shift
    // wb <= mem <= ex reads the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex    <= '0;
            r_mem   <= '0;
            r_wb    <= '0;
            r_state <= ST_RUN;
            r_cnt   <= 3'd0;
        end else begin
            // The downstream shift never stops; only the EX capture is gated.
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_capture ? w_id_entry : '0;

            if (flush) begin
                r_state <= ST_RUN;
                r_cnt   <= 3'd0;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        // With a single-cycle stall the load moves to MEM on
                        // this edge, so the hazard clears without HOLD.
                        if (w_haz && MULTI_STALL) begin
                            r_cnt   <= HOLD_CYCLES;
                            r_state <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (r_cnt == 3'd1) begin
                            r_cnt   <= 3'd0;
                            r_state <= ST_RUN;
                        end else begin
                            r_cnt <= r_cnt - 3'd1;
                        end
                    end
                    default: begin
                        r_cnt   <= 3'd0;
                        r_state <= ST_RUN;
                    end
                endcase
            end
        end
    end

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule
